// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1-to-2 packet stream demultiplexer.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/stream_demux1x2_if.sv
// Bundle of the demux input stream, both output streams and the packet counters.
interface stream_demux1x2_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_sel;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_last;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_last;
    logic             out1_ready;

    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;

    // Demux side
    modport slave (
        input  in_data, in_valid, in_last, in_sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out0_last,
        output out1_data, out1_valid, out1_last, pkt_cnt0, pkt_cnt1
    );

    // Source/sink side
    modport master (
        output in_data, in_valid, in_last, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out0_last,
        input  out1_data, out1_valid, out1_last, pkt_cnt0, pkt_cnt1
    );

endinterface

// File: rtl/demux_out_slice.sv
// One-entry output register slice with a saturating count of completed packets.
module demux_out_slice
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             can_accept,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_cnt
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    assign can_accept = !valid_q || out_ready;
    assign drain      = valid_q && out_ready;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (drain) valid_d = 1'b0;
        // A write in the same cycle as a drain overrides the clear
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            last_d  = wr_last;
        end
        if (drain && last_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign pkt_cnt   = cnt_q;

endmodule

// File: rtl/stream_demux1x2.sv
// Packet-granular 1-to-2 stream demux: destination locked on the first beat of each packet.
module stream_demux1x2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst_n,
    stream_demux1x2_if.slave  bus
);

    state_e state_q, state_d;
    logic   tgt;
    logic   acc0, acc1;
    logic   in_fire;

    always_comb begin
        tgt = 1'b0;
        unique case (state_q)
            IDLE:    tgt = bus.in_sel;
            ROUTE0:  tgt = 1'b0;
            ROUTE1:  tgt = 1'b1;
            default: tgt = 1'b0;
        endcase
    end

    // Ready is a pure function of the target slice, never of in_valid
    assign bus.in_ready = tgt ? acc1 : acc0;
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        if (in_fire) begin
            if (bus.in_last)     state_d = IDLE;
            else if (state_q == IDLE) state_d = bus.in_sel ? ROUTE1 : ROUTE0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    demux_out_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slice0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (in_fire && !tgt),
        .wr_data    (bus.in_data),
        .wr_last    (bus.in_last),
        .can_accept (acc0),
        .out_data   (bus.out0_data),
        .out_valid  (bus.out0_valid),
        .out_last   (bus.out0_last),
        .out_ready  (bus.out0_ready),
        .pkt_cnt    (bus.pkt_cnt0)
    );

    demux_out_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slice1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (in_fire && tgt),
        .wr_data    (bus.in_data),
        .wr_last    (bus.in_last),
        .can_accept (acc1),
        .out_data   (bus.out1_data),
        .out_valid  (bus.out1_valid),
        .out_last   (bus.out1_last),
        .out_ready  (bus.out1_ready),
        .pkt_cnt    (bus.pkt_cnt1)
    );

endmodule

// File: doc/stream_demux1x2.md
STREAM_DEMUX1X2 -- requirements
Module: stream_demux1x2

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width of input and both outputs.
REQ-002 Parameter CNT_W, default 16, sets the width of each per-output packet counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  input beat payload.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_last  input  1  marks final beat of a packet.
REQ-008 in_sel  input  1  destination (0 = out0, 1 = out1); sampled only on the first beat of a packet.
REQ-009 in_ready  output  1  block accepts the input beat this cycle.
REQ-010 out0_data / out1_data  output  WIDTH  registered payload per output.
REQ-011 out0_valid / out1_valid  output  1  output beat present.
REQ-012 out0_last / out1_last  output  1  registered copy of in_last.
REQ-013 out0_ready / out1_ready  input  1  downstream accepts the beat.
REQ-014 pkt_cnt0 / pkt_cnt1  output  CNT_W  packets completed on each output.

Function
REQ-015 A transfer occurs on a port when valid and ready are both high at a rising clk edge.
REQ-016 The routing FSM has exactly three states: IDLE, ROUTE0, ROUTE1.
REQ-017 In IDLE, the target is in_sel; otherwise, the target is 0 in ROUTE0 and 1 in ROUTE1.
REQ-018 In IDLE, an accepted beat with in_last=0 moves the FSM to ROUTE0 or ROUTE1 according to in_sel.
REQ-019 In IDLE, an accepted beat with in_last=1 (single-beat packet) leaves the FSM in IDLE.
REQ-020 In ROUTEx, an accepted beat with in_last=1 returns the FSM to IDLE; in_sel is ignored in ROUTEx.
REQ-021 In ROUTEx, the FSM holds state while in_valid=0 (gaps allowed mid-packet).
REQ-022 Each output has a one-entry register slice that can accept a beat when its valid is low or its ready is high.
REQ-023 in_ready equals the accept condition of the target slice, is combinational, and does not depend on in_valid.
REQ-024 An accepted beat appears on the target output with its valid high on the cycle after acceptance (latency 1).
REQ-025 Throughput is one beat per cycle when the target output's ready is held high.
REQ-026 While outX_valid=1 and outX_ready=0, outX_data and outX_last hold stable.
REQ-027 A beat is never written to the non-target slice; the non-target output drains independently.
REQ-028 pkt_cntX increments by 1 on each outX transfer with outX_last=1.
REQ-029 pkt_cntX saturates at all-ones and does not wrap.
REQ-030 Simultaneous fill and drain on the same slice in one cycle keeps valid high and loads the new beat.

Reset
REQ-031 With rst_n low, the FSM is in IDLE, out0_valid=out1_valid=0, and pkt_cnt0=pkt_cnt1=0.
REQ-032 With rst_n low, data and last registers are 0.
REQ-033 With rst_n low, in_ready reflects empty slices, i.e. 1.
REQ-034 Reset asserted mid-packet discards any partial packet and buffered beats.
REQ-035 After reset is released, the next accepted beat is treated as a packet start.

Structure
REQ-036 Package demux_pkg holds the FSM state enumeration (IDLE, ROUTE0, ROUTE1) and the default WIDTH and CNT_W constants.
REQ-037 The per-output register slice plus its packet counter is one sub-module, demux_out_slice, instantiated twice.

Verification
REQ-038 Single-beat packet: in_sel=0, data 8'hA5, last=1, out0_ready=1 -> out0 shows A5/last=1 one cycle later; out1_valid stays 0; pkt_cnt0=1.
REQ-039 Sel lock: 3-beat packet 11,22,33 with in_sel=1 on beat 1 and in_sel=0 on beats 2-3 -> all three beats on out1, FSM returns to IDLE, pkt_cnt1=1.
REQ-040 Backpressure: out1_ready=0 with beat 5A buffered -> in_ready=0 for target 1, out1_data holds 5A; out1_ready=1 -> 5A consumed, in_ready=1.
REQ-041 Independence: out0 stalled holding 77, packet 88 sent to out1 -> 88 delivered on out1 while out0 still holds 77.
REQ-042 Reset mid-packet: after 2 of 4 beats, pulse rst_n low -> valids 0, counters 0; next beat with in_sel=1 routes to out1.
REQ-043 Saturation: with CNT_W=2, 5 single-beat packets to out0 -> pkt_cnt0 reads 3.
